// File: rtl/trace_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_buffer_ctrl_pkg
// Brief    : Shared FSM state encoding and output-FIFO sizing rule for the
//            trace buffer controller.
// Revision : 1.0
// ============================================================================
package trace_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Two spare slots beyond the RAM pipeline let reads stream at full rate.
  function automatic int fifo_depth(input int ram_latency);
    return ram_latency + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trace_buffer_ctrl
// Brief    : Circular trace capture into an external dual-port RAM with a
//            credit-controlled, latency-tolerant oldest-first drain path.
// Revision : 1.0
// ============================================================================
module trace_buffer_ctrl
  import trace_buffer_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              cmd_drain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              drain_done,
  output logic              capturing,
  output logic              wrapped,
  output logic [ADDR_W:0]   count,
  output logic              ram_clken,
  output logic              ram_wren_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_wren_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam int c_FIFO_D = fifo_depth(RAM_LATENCY);
  localparam int c_IDX_W  = $clog2(c_FIFO_D);
  localparam int c_CNT_W  = $clog2(c_FIFO_D + 1);
  localparam logic [ADDR_W:0]    c_DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_FIFO_D - 1);
  localparam logic [c_CNT_W:0]   c_CREDIT    = (c_CNT_W + 1)'(c_FIFO_D);

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W:0]        r_count;
  logic [ADDR_W:0]        r_remaining;
  logic                   r_wrapped;
  logic                   r_drain_done;
  logic [RAM_LATENCY-1:0] r_vld;
  logic [c_CNT_W-1:0]     r_in_flight;
  logic [c_CNT_W-1:0]     r_occ;
  logic [c_IDX_W-1:0]     r_fifo_wr;
  logic [c_IDX_W-1:0]     r_fifo_rd;
  logic [DATA_W-1:0]      r_fifo [c_FIFO_D];

  logic w_wr_en, w_issue, w_start, w_enter_drain, w_done_nxt;
  logic w_push, w_pop, w_credit;

  assign w_push   = r_vld[RAM_LATENCY-1];
  assign w_pop    = out_valid && out_ready;
  // Reads in flight already own a FIFO slot, so they count against the credit.
  assign w_credit = ({1'b0, r_in_flight} + {1'b0, r_occ}) < c_CREDIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en       = 1'b0;
    w_issue       = 1'b0;
    w_start       = 1'b0;
    w_enter_drain = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_start) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CAPTURE;
        end else if (cmd_drain) begin
          if (r_count != '0) begin
            w_enter_drain = 1'b1;
            w_state_nxt   = ST_DRAIN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        w_wr_en = in_valid;
        if (cmd_stop) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        w_issue = (r_remaining != '0) && w_credit;
        if (r_remaining == '0 && r_in_flight == '0 && r_occ == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_remaining  <= '0;
      r_wrapped    <= 1'b0;
      r_drain_done <= 1'b0;
      r_vld        <= '0;
      r_in_flight  <= '0;
      r_occ        <= '0;
      r_fifo_wr    <= '0;
      r_fifo_rd    <= '0;
    end else begin
      r_drain_done <= w_done_nxt;

      if (w_start) begin
        r_wr_ptr  <= '0;
        r_count   <= '0;
        r_wrapped <= 1'b0;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != c_DEPTH_CNT) r_count <= r_count + 1'b1;
        if (&r_wr_ptr) r_wrapped <= 1'b1;
      end

      // Once wrapped, the write pointer marks the oldest surviving entry.
      if (w_enter_drain) begin
        r_rd_ptr    <= r_wrapped ? r_wr_ptr : '0;
        r_remaining <= r_count;
      end else if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end

      r_vld[0] <= w_issue;
      for (int i = 1; i < RAM_LATENCY; i++) r_vld[i] <= r_vld[i-1];
      r_in_flight <= r_in_flight + c_CNT_W'(w_issue) - c_CNT_W'(w_push);

      r_occ <= r_occ + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      if (w_push) r_fifo_wr <= (r_fifo_wr == c_IDX_LAST) ? '0 : r_fifo_wr + 1'b1;
      if (w_pop)  r_fifo_rd <= (r_fifo_rd == c_IDX_LAST) ? '0 : r_fifo_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_fifo_wr] <= ram_q_b;
  end

  assign out_valid  = (r_occ != '0);
  assign out_data   = r_fifo[r_fifo_rd];
  assign drain_done = r_drain_done;
  assign capturing  = (r_state == ST_CAPTURE);
  assign wrapped    = r_wrapped;
  assign count      = r_count;

  assign ram_clken  = 1'b1;
  assign ram_wren_a = w_wr_en;
  assign ram_addr_a = r_wr_ptr;
  assign ram_data_a = in_data;
  assign ram_wren_b = 1'b0;
  assign ram_data_b = '0;
  assign ram_addr_b = r_rd_ptr;

endmodule
`default_nettype wire

// File: tb/tb_trace_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_buffer_ctrl
// Brief    : Self-checking bench: reference buffer model, RAM model and an
//            output scoreboard for trace_buffer_ctrl (ADDR_W=3, latency 2).
// Revision : 1.0
// ============================================================================
module tb_trace_buffer_ctrl;

  localparam int c_DW    = 32;
  localparam int c_AW    = 3;
  localparam int c_LAT   = 2;
  localparam int c_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [c_DW-1:0]   in_data = '0;
  logic              cmd_start = 1'b0, cmd_stop = 1'b0, cmd_drain = 1'b0;
  logic              out_valid, out_ready = 1'b1;
  logic [c_DW-1:0]   out_data;
  logic              drain_done, capturing, wrapped;
  logic [c_AW:0]     count;
  logic              ram_clken, ram_wren_a, ram_wren_b;
  logic [c_AW-1:0]   ram_addr_a, ram_addr_b;
  logic [c_DW-1:0]   ram_data_a, ram_data_b, ram_q_b;

  trace_buffer_ctrl #(.DATA_W(c_DW), .ADDR_W(c_AW), .RAM_LATENCY(c_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_drain(cmd_drain),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drain_done(drain_done), .capturing(capturing), .wrapped(wrapped),
    .count(count), .ram_clken(ram_clken), .ram_wren_a(ram_wren_a),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_wren_b(ram_wren_b),
    .ram_data_b(ram_data_b), .ram_addr_b(ram_addr_b), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // Two-stage registered-read RAM.
  logic [c_DW-1:0] ram [c_DEPTH];
  logic [c_DW-1:0] rq0, rq1;
  always @(posedge clk) begin
    if (ram_wren_a) ram[ram_addr_a] <= ram_data_a;
    rq0 <= ram[ram_addr_b];
    rq1 <= rq0;
  end
  assign ram_q_b = rq1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference buffer model.
  logic [c_DW-1:0] m_mem [c_DEPTH];
  int m_wr = 0, m_count = 0;
  bit m_wrapped = 0, m_cap = 0;
  logic [c_DW-1:0] sb [$];

  // Monitor: scoreboard pops, stall stability, drain_done pulses.
  int  done_cnt = 0;
  int  max_occ  = 0;
  bit  prev_valid = 0, prev_ready = 0;
  logic [c_DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      if (int'(dut.r_occ) > max_occ) max_occ = int'(dut.r_occ);
      if (drain_done) done_cnt++;
      if (out_valid && prev_valid && !prev_ready)
        check("stall_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
        else                check("out_data", out_data, sb.pop_front());
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  // Consumer ready pattern: 0 = always, 1 = toggle, 2 = random.
  int ready_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    m_wr = 0; m_count = 0; m_wrapped = 0;
  endtask

  task automatic do_start();
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    model_clear(); m_cap = 1;
  endtask

  task automatic do_stop();
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    m_cap = 0;
  endtask

  task automatic push_vec(input logic [c_DW-1:0] d, input bit stop);
    in_valid = 1'b1; in_data = d; cmd_stop = stop;
    #1;
    check("ram_wren_a", ram_wren_a, m_cap);
    if (m_cap) begin
      check("ram_addr_a", ram_addr_a, m_wr);
      m_mem[m_wr] = d;
      m_wr = (m_wr + 1) % c_DEPTH;
      if (m_wr == 0) m_wrapped = 1;
      if (m_count < c_DEPTH) m_count++;
    end
    if (stop) m_cap = 0;
    tick();
    in_valid = 1'b0; cmd_stop = 1'b0;
  endtask

  task automatic do_drain();
    if (m_count > 0) begin
      if (m_wrapped) for (int i = 0; i < c_DEPTH; i++) sb.push_back(m_mem[(m_wr + i) % c_DEPTH]);
      else           for (int i = 0; i < m_count; i++) sb.push_back(m_mem[i]);
    end
    cmd_drain = 1'b1; tick(); cmd_drain = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (drain_done) break;
      tick();
    end
    check("drain_done_seen", drain_done, 1);
  endtask

  typedef struct {
    int              n;
    logic [c_DW-1:0] base;
    int              mode;
    int              exp_count;
    bit              exp_wrapped;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, lat;
    tbl[0] = '{n: 5,  base: 32'h10, mode: 0, exp_count: 5, exp_wrapped: 0};
    tbl[1] = '{n: 11, base: 32'h01, mode: 0, exp_count: 8, exp_wrapped: 1};
    tbl[2] = '{n: 8,  base: 32'h20, mode: 1, exp_count: 8, exp_wrapped: 1};
    tbl[3] = '{n: 3,  base: 32'h40, mode: 1, exp_count: 3, exp_wrapped: 0};
    tbl[4] = '{n: 7,  base: 32'h50, mode: 2, exp_count: 7, exp_wrapped: 0};

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_capturing", capturing, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_ram_wren_a", ram_wren_a, 0);
    check("ram_clken", ram_clken, 1);
    check("ram_wren_b", ram_wren_b, 0);
    check("ram_data_b", ram_data_b, 0);
    rst_n = 1'b1;
    tick();

    // Empty drain: immediate done, no output
    d0 = done_cnt;
    do_drain();
    check("empty_drain_done", drain_done, 1);
    repeat (6) tick();
    check("empty_drain_pulses", done_cnt, d0 + 1);

    // in_valid dropped while idle
    push_vec(32'hDEAD, 0);
    check("idle_count", count, 0);

    for (int r = 0; r < 5; r++) begin
      ready_mode = tbl[r].mode;
      do_start();
      check("capturing", capturing, 1);
      for (int i = 0; i < tbl[r].n; i++) push_vec(tbl[r].base + 32'(i), 0);
      do_stop();
      check("capturing_off", capturing, 0);
      check("count", count, tbl[r].exp_count);
      check("wrapped", wrapped, tbl[r].exp_wrapped);
      d0 = done_cnt;
      do_drain();
      if (r == 0) begin
        lat = 1;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("drain_latency", lat, c_LAT + 2);
      end
      wait_done();
      tick();
      check("sb_empty", sb.size(), 0);
      check("done_once", done_cnt, d0 + 1);
      check("count_kept", count, tbl[r].exp_count);
    end
    ready_mode = 0;

    // cmd_start beats cmd_drain; commands ignored during capture
    cmd_start = 1'b1; cmd_drain = 1'b1; tick(); cmd_start = 1'b0; cmd_drain = 1'b0;
    model_clear(); m_cap = 1;
    check("start_beats_drain", capturing, 1);
    check("start_clears_count", count, 0);
    cmd_drain = 1'b1; tick(); cmd_drain = 1'b0;
    check("drain_ignored_in_capture", capturing, 1);

    // Stop with a same-cycle write; later writes dropped
    push_vec(32'hA0, 0);
    push_vec(32'hA1, 0);
    push_vec(32'hAB, 1);
    check("stop_write_count", count, 3);
    push_vec(32'hCD, 0);
    check("after_stop_count", count, 3);
    d0 = done_cnt;
    do_drain();
    wait_done();
    tick();
    check("stop_sb_empty", sb.size(), 0);

    // Repeat drain of the same contents
    do_drain();
    wait_done();
    tick();
    check("repeat_sb_empty", sb.size(), 0);

    // Reset in the middle of a drain
    do_start();
    for (int i = 0; i < 6; i++) push_vec(32'h70 + 32'(i), 0);
    do_stop();
    do_drain();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_count", count, 0);
    sb.delete();
    model_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    d0 = done_cnt;
    do_drain();
    check("post_rst_done", drain_done, 1);
    repeat (10) tick();
    check("post_rst_done_once", done_cnt, d0 + 1);
    check("post_rst_out_valid", out_valid, 0);

    check("fifo_max_occ_ok", max_occ <= c_LAT + 2, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_buffer_ctrl.md
TRACE_BUFFER_CTRL -- requirements
Module: trace_buffer_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, trace vector width; ADDR_W, default 8, RAM address width (DEPTH = 2^ADDR_W); RAM_LATENCY, default 2, cycles from ram_addr_b to valid ram_q_b.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  trace vector present
- in_data  in  DATA_W  trace vector
- cmd_start  in  1  clear and begin capture (pulse)
- cmd_stop  in  1  freeze capture (pulse)
- cmd_drain  in  1  stream stored contents out (pulse)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  DATA_W  drained vector, oldest first
- drain_done  out  1  one-cycle pulse, drain finished
- capturing  out  1  state == CAPTURE
- wrapped  out  1  buffer has overwritten at least once since start
- count  out  ADDR_W+1  valid entries stored, saturates at DEPTH
- ram_clken  out  1  tied 1
- ram_wren_a, ram_addr_a, ram_data_a  out  1/ADDR_W/DATA_W  RAM port A write
- ram_wren_b, ram_data_b  out  1/DATA_W  tied 0
- ram_addr_b  out  ADDR_W  RAM port B read address
- ram_q_b  in  DATA_W  RAM port B read data

Function
REQ-003 SHALL implement FSM states IDLE, CAPTURE, DRAIN; reset state IDLE.
REQ-004 IDLE: cmd_start -> CAPTURE with wr_ptr=0, count=0, wrapped=0; else cmd_drain with count>0 -> DRAIN; cmd_drain with count==0 -> stay IDLE, drain_done pulses next cycle; cmd_start beats cmd_drain.
REQ-005 CAPTURE: each cycle with in_valid: ram_wren_a=1, ram_addr_a=wr_ptr, ram_data_a=in_data (same cycle, combinational); wr_ptr increments modulo DEPTH; count increments, saturating at DEPTH.
REQ-006 wrapped SHALL set on the cycle wr_ptr wraps from DEPTH-1 to 0 and stay set until next cmd_start.
REQ-007 CAPTURE: cmd_stop -> IDLE; a write with in_valid in that same cycle SHALL still be performed; cmd_start/cmd_drain ignored in CAPTURE.
REQ-008 in_valid outside CAPTURE SHALL be dropped; ram_wren_a=0.
REQ-009 DRAIN entry: rd_ptr = wrapped ? wr_ptr : 0; remaining = count; count, wr_ptr, wrapped unchanged (repeat drains allowed).
REQ-010 DRAIN: a read is issued (ram_addr_b=rd_ptr, rd_ptr++ mod DEPTH, remaining--) when remaining>0 and in_flight + fifo_occupancy < RAM_LATENCY+2.
REQ-011 Read data SHALL be captured from ram_q_b exactly RAM_LATENCY cycles after issue into an output FIFO of depth RAM_LATENCY+2; FIFO never overflows.
REQ-012 out_valid = FIFO non-empty; entry retired when out_valid && out_ready; out_data stable while out_valid && !out_ready.
REQ-013 Minimum latency cmd_drain -> first out_valid = RAM_LATENCY+2 cycles; with out_ready held 1, one vector per cycle sustained.
REQ-014 DRAIN -> IDLE when remaining==0, in_flight==0, FIFO empty; drain_done pulses one cycle on that transition; cmd_* ignored in DRAIN.
REQ-015 Drain order SHALL be oldest to newest: DEPTH entries from wr_ptr if wrapped, else entries 0..count-1.

Reset
REQ-016 rst_n low SHALL asynchronously force: state IDLE, wr_ptr=0, rd_ptr=0, count=0, wrapped=0, remaining=0, in_flight=0, FIFO empty, out_valid=0, drain_done=0, capturing=0, ram_wren_a=0.
REQ-017 Reset mid-DRAIN SHALL discard all in-flight reads; no out_valid after release until a new drain.
REQ-018 RAM contents are not cleared by reset.

Structure
REQ-019 FSM state enum and the FIFO depth rule (RAM_LATENCY+2) SHALL live in the shared trace package.
REQ-020 No sub-module; ram_dual_port is instantiated by the parent and connected via the ram_* ports; the read-data valid shift register and FIFO are internal.

Verification
REQ-021 start, 5 vectors 0x10..0x14, stop, drain, out_ready=1 -> out 0x10..0x14 consecutive, drain_done once, count=5, wrapped=0.
REQ-022 ADDR_W=3, start, 11 vectors 1..11, stop, drain -> out 4..11, wrapped=1, count=8.
REQ-023 drain with out_ready toggling 1/0 every cycle, RAM_LATENCY=2 -> no loss/duplication, out_data stable while stalled, FIFO never exceeds 4.
REQ-024 cmd_stop with in_valid same cycle, data 0xAB -> 0xAB stored as last entry; in_valid after stop -> count unchanged.
REQ-025 rst_n low 3 cycles after cmd_drain -> out_valid=0 immediately, count=0; after release, cmd_drain -> drain_done with no out_valid.
REQ-026 cmd_drain with count=0 -> drain_done one cycle later, no RAM reads issued.
